// File: rtl/dot_product_sequencer.sv
// Control sequencer for one dot product on the 24-bit accumulator datapath.
// Issues operand reads and latch/clear/MAC strobes, then writes AC back to memory.
module dot_product_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] b_stride,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              ac_to_bus,
    output logic              opr_ld,
    output logic              ac_clear,
    output logic              alu_to_ac,
    output logic              alu_mac,
    output logic [2:0]        dbg_state
);

    // Handshake: start is only looked at in IDLE, where it latches all operand
    // inputs; done is a single-cycle pulse and start is never queued while busy.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_RD_A   = 3'd2;
    localparam logic [2:0] S_WAIT_A = 3'd3;
    localparam logic [2:0] S_RD_B   = 3'd4;
    localparam logic [2:0] S_WAIT_B = 3'd5;
    localparam logic [2:0] S_STORE  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  wcnt, wcnt_nxt;
    logic [LEN_W:0]    i_cnt, i_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] pa, pa_nxt, pb, pb_nxt, stride_q, c_q;

    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = '0;
        i_nxt     = i_cnt;
        pa_nxt    = pa;
        pb_nxt    = pb;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                    i_nxt     = '0;
                    pa_nxt    = a_base;
                    pb_nxt    = b_base;
                end
            end
            S_CLEAR:  state_nxt = (len_q != '0) ? S_RD_A : S_STORE;
            S_RD_A:   state_nxt = S_WAIT_A;
            S_WAIT_A: begin
                if (wcnt == LAT_LAST) state_nxt = S_RD_B;
                else                  wcnt_nxt  = wcnt + 1'b1;
            end
            S_RD_B:   state_nxt = S_WAIT_B;
            S_WAIT_B: begin
                if (wcnt == LAT_LAST) begin
                    // i is one bit wider than len so len = 2**LEN_W-1 still terminates
                    i_nxt     = i_cnt + 1'b1;
                    pa_nxt    = pa + 1'b1;
                    pb_nxt    = pb + stride_q;
                    state_nxt = (i_nxt < {1'b0, len_q}) ? S_RD_A : S_STORE;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            S_STORE:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            i_cnt     <= '0;
            pa        <= '0;
            pb        <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            c_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            ac_to_bus <= 1'b0;
            opr_ld    <= 1'b0;
            ac_clear  <= 1'b0;
            alu_to_ac <= 1'b0;
            alu_mac   <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            i_cnt <= i_nxt;
            pa    <= pa_nxt;
            pb    <= pb_nxt;
            if (state == S_IDLE && start) begin
                stride_q <= b_stride;
                len_q    <= len;
                c_q      <= c_addr;
            end
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            mem_rd    <= (state_nxt == S_RD_A) || (state_nxt == S_RD_B);
            mem_wr    <= (state_nxt == S_STORE);
            ac_to_bus <= (state_nxt == S_STORE);
            ac_clear  <= (state_nxt == S_CLEAR);
            opr_ld    <= (state_nxt == S_WAIT_A) && (wcnt_nxt == LAT_LAST);
            alu_mac   <= (state_nxt == S_WAIT_B) && (wcnt_nxt == LAT_LAST);
            alu_to_ac <= (state_nxt == S_WAIT_B) && (wcnt_nxt == LAT_LAST);
            case (state_nxt)
                S_RD_A:  mem_addr <= pa_nxt;
                S_RD_B:  mem_addr <= pb_nxt;
                S_STORE: mem_addr <= c_q;
                default: mem_addr <= mem_addr;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: two instances (MEM_LAT 1 and 3) each drive an
// emulated memory/accumulator datapath; results are checked against a dot-product model.
module tb_dot_product_sequencer;
    localparam int AW = 16;
    localparam int LW = 8;
    localparam int W  = 24;
    localparam logic [W-1:0] POISON = 24'hA5A5A5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_v [2];
    logic [AW-1:0] a_base, b_base, b_stride, c_addr;
    logic [LW-1:0] len;
    logic [W-1:0] mem [0:65535];

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] got_q [$];

    int r_lat, r_nwr, r_ndone, r_nviol;
    logic [W-1:0] r_wd;
    logic [AW-1:0] r_wa;
    logic r_busy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int LAT = (g == 0) ? 1 : 3;
        logic busy, done, mem_rd, mem_wr, ac_to_bus, opr_ld, ac_clear, alu_to_ac, alu_mac;
        logic [AW-1:0] mem_addr, wr_addr;
        logic [AW-1:0] rd_log [0:1023];
        logic [2:0] dbg_state;
        logic [W-1:0] pipe [0:LAT-1];
        logic [W-1:0] ac, r_reg, wr_data;
        logic [8:0] outs;
        int rd_n = 0, done_n = 0, wr_n = 0, viol = 0, cyc = 0, last_rd = 0;

        assign outs = {busy, done, mem_rd, mem_wr, ac_to_bus, opr_ld, ac_clear, alu_to_ac, alu_mac};

        dot_product_sequencer #(.ADDR_W(AW), .LEN_W(LW), .MEM_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]),
            .a_base(a_base), .b_base(b_base), .b_stride(b_stride), .len(len), .c_addr(c_addr),
            .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
            .ac_to_bus(ac_to_bus), .opr_ld(opr_ld), .ac_clear(ac_clear),
            .alu_to_ac(alu_to_ac), .alu_mac(alu_mac), .dbg_state(dbg_state)
        );

        // Memory with LAT-cycle read latency plus the R/AC datapath the strobes steer.
        always @(posedge clk) begin : p_env
            logic [W-1:0] md;
            int v;
            md = pipe[LAT-1];
            v = 0;
            if (mem_rd && mem_wr) v++;
            if (ac_clear && alu_to_ac) v++;
            if (alu_to_ac != alu_mac) v++;
            if (mem_wr != ac_to_bus) v++;
            if (!busy && (mem_rd || mem_wr || opr_ld || ac_clear || alu_mac || done)) v++;
            if ((opr_ld || alu_mac) && (cyc - last_rd != LAT)) v++;
            viol <= viol + v;
            cyc <= cyc + 1;
            if (mem_rd) begin
                rd_log[rd_n % 1024] <= mem_addr;
                rd_n <= rd_n + 1;
                last_rd <= cyc;
            end
            if (ac_clear) ac <= '0;
            if (opr_ld) r_reg <= md;
            if (alu_mac && alu_to_ac) ac <= ac + r_reg * md;
            if (mem_wr) begin
                wr_addr <= mem_addr;
                wr_data <= ac;
                wr_n <= wr_n + 1;
            end
            if (done) done_n <= done_n + 1;
            for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= mem_rd ? mem[mem_addr] : POISON;
        end
    end

    int sel = 0;
    logic [8:0] outs_s;
    logic [AW-1:0] addr_s, wr_addr_s;
    logic [W-1:0] wr_data_s;
    logic done_s, busy_s;
    int rd_n_s, done_n_s, wr_n_s, viol_s;

    always_comb begin
        if (sel == 0) begin
            outs_s = g_env[0].outs; addr_s = g_env[0].mem_addr;
            wr_addr_s = g_env[0].wr_addr; wr_data_s = g_env[0].wr_data;
            rd_n_s = g_env[0].rd_n; done_n_s = g_env[0].done_n;
            wr_n_s = g_env[0].wr_n; viol_s = g_env[0].viol;
        end else begin
            outs_s = g_env[1].outs; addr_s = g_env[1].mem_addr;
            wr_addr_s = g_env[1].wr_addr; wr_data_s = g_env[1].wr_data;
            rd_n_s = g_env[1].rd_n; done_n_s = g_env[1].done_n;
            wr_n_s = g_env[1].wr_n; viol_s = g_env[1].viol;
        end
        busy_s = outs_s[8];
        done_s = outs_s[7];
    end

    function automatic logic [AW-1:0] get_rd(input int s, input int k);
        if (s == 0) return g_env[0].rd_log[k % 1024];
        return g_env[1].rd_log[k % 1024];
    endfunction

    task automatic fill_mem(input logic [AW-1:0] ab, bb, st, input logic [LW-1:0] ln);
        for (int i = 0; i < int'(ln); i++) begin
            mem[AW'(ab + AW'(i))] = W'($urandom);
            mem[AW'(bb + st * AW'(i))] = W'($urandom);
        end
    endtask

    // Reference: expected read order and the dot product modulo 2**24.
    task automatic model_dot(input logic [AW-1:0] ab, bb, st, input logic [LW-1:0] ln,
                             output logic [W-1:0] es);
        logic [AW-1:0] pa_m, pb_m;
        logic [2*W-1:0] prod;
        es = '0;
        exp_q.delete();
        for (int i = 0; i < int'(ln); i++) begin
            pa_m = AW'(ab + AW'(i));
            pb_m = AW'(bb + st * AW'(i));
            exp_q.push_back(pa_m);
            exp_q.push_back(pb_m);
            prod = mem[pa_m] * mem[pb_m];
            es = W'(es + prod);
        end
    endtask

    task automatic run_dot(input int s, input logic [AW-1:0] ab, bb, st,
                           input logic [LW-1:0] ln, input logic [AW-1:0] ca);
        int rd0, wr0, dn0, v0, n;
        sel = s;
        #1;
        rd0 = rd_n_s; wr0 = wr_n_s; dn0 = done_n_s; v0 = viol_s;
        a_base = ab; b_base = bb; b_stride = st; len = ln; c_addr = ca;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        a_base = AW'($urandom); b_base = AW'($urandom); b_stride = AW'($urandom);
        len = LW'($urandom); c_addr = AW'($urandom);
        n = 0;
        while (!done_s && n < 2 + 8 * int'(ln) + 20) begin
            @(posedge clk); #1;
            n++;
        end
        r_lat = done_s ? n : -1;
        r_wd = wr_data_s;
        r_wa = wr_addr_s;
        got_q.delete();
        for (int k = rd0; k < rd_n_s; k++) got_q.push_back(get_rd(s, k));
        @(posedge clk); #1;
        r_nwr = wr_n_s - wr0;
        r_ndone = done_n_s - dn0;
        r_nviol = viol_s - v0;
        r_busy = busy_s;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            tests++;
            if ({outs_s, addr_s} !== '0) begin
                fails++;
                $display("FAIL reset_outputs inst%0d got %h expected 0", s, {outs_s, addr_s});
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        #1;
        tests++;
        if (outs_s !== 9'd0) begin
            fails++;
            $display("FAIL idle_after_reset got %b expected 0", outs_s);
        end
    endtask

    task automatic test_spec_vector();
        logic [W-1:0] es;
        mem[16'h10] = 24'd2; mem[16'h11] = 24'd3; mem[16'h12] = 24'd4;
        mem[16'h20] = 24'd5; mem[16'h21] = 24'd6; mem[16'h22] = 24'd7;
        model_dot(16'h10, 16'h20, 16'd1, 8'd3, es);
        run_dot(0, 16'h10, 16'h20, 16'd1, 8'd3, 16'h30);
        tests++;
        if (r_wd !== 24'd56 || r_wa !== 16'h30) begin
            fails++;
            $display("FAIL spec_vector_result got %0d@%h expected 56@30", r_wd, r_wa);
        end
        tests++;
        if (r_lat != 14) begin
            fails++;
            $display("FAIL spec_vector_latency got %0d expected 14", r_lat);
        end
        tests++;
        if (got_q.size() != exp_q.size() || got_q.size() != 6 || got_q[0] !== 16'h10 ||
            got_q[1] !== 16'h20 || got_q[4] !== 16'h12 || got_q[5] !== 16'h22) begin
            fails++;
            $display("FAIL spec_vector_reads got %0d reads expected 6 (10,20,11,21,12,22)", got_q.size());
        end
        tests++;
        if (r_ndone != 1 || r_nwr != 1 || r_nviol != 0 || r_busy !== 1'b0) begin
            fails++;
            $display("FAIL spec_vector_strobes got done=%0d wr=%0d viol=%0d busy=%b expected 1 1 0 0",
                     r_ndone, r_nwr, r_nviol, r_busy);
        end
    endtask

    task automatic test_len_zero();
        run_dot(0, 16'h100, 16'h200, 16'd1, 8'd0, 16'h77);
        tests++;
        if (r_lat != 2) begin
            fails++;
            $display("FAIL len_zero_latency got %0d expected 2", r_lat);
        end
        tests++;
        if (got_q.size() != 0 || r_wd !== '0 || r_wa !== 16'h77 || r_nwr != 1) begin
            fails++;
            $display("FAIL len_zero_store got reads=%0d data=%h addr=%h wr=%0d expected 0 0 77 1",
                     got_q.size(), r_wd, r_wa, r_nwr);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] es;
        fill_mem(16'h40, 16'hFFFE, 16'd3, 8'd2);
        model_dot(16'h40, 16'hFFFE, 16'd3, 8'd2, es);
        run_dot(0, 16'h40, 16'hFFFE, 16'd3, 8'd2, 16'h50);
        tests++;
        if (got_q.size() != 4 || got_q[1] !== 16'hFFFE || got_q[3] !== 16'h0001) begin
            fails++;
            $display("FAIL wrap_b_addr got %0d reads, b=%h,%h expected fffe,0001",
                     got_q.size(), got_q.size() > 1 ? got_q[1] : 16'h0, got_q.size() > 3 ? got_q[3] : 16'h0);
        end
        tests++;
        if (r_wd !== es) begin
            fails++;
            $display("FAIL wrap_result got %h expected %h", r_wd, es);
        end
    endtask

    task automatic test_mem_lat3();
        logic [W-1:0] es;
        fill_mem(16'h500, 16'h600, 16'd4, 8'd2);
        model_dot(16'h500, 16'h600, 16'd4, 8'd2, es);
        run_dot(1, 16'h500, 16'h600, 16'd4, 8'd2, 16'h700);
        tests++;
        if (r_lat != 18) begin
            fails++;
            $display("FAIL lat3_latency got %0d expected 18", r_lat);
        end
        tests++;
        if (r_wd !== es || r_nviol != 0 || r_ndone != 1) begin
            fails++;
            $display("FAIL lat3_result got %h viol=%0d done=%0d expected %h 0 1", r_wd, r_nviol, r_ndone, es);
        end
    endtask

    task automatic test_max_len();
        logic [W-1:0] es;
        fill_mem(16'h1000, 16'h2000, 16'd1, 8'd255);
        model_dot(16'h1000, 16'h2000, 16'd1, 8'd255, es);
        run_dot(0, 16'h1000, 16'h2000, 16'd1, 8'd255, 16'h3000);
        tests++;
        if (r_lat != 1022 || got_q.size() != 510) begin
            fails++;
            $display("FAIL max_len_run got lat=%0d reads=%0d expected 1022 510", r_lat, got_q.size());
        end
        tests++;
        if (r_wd !== es) begin
            fails++;
            $display("FAIL max_len_result got %h expected %h", r_wd, es);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] ab, bb, st, ca;
        logic [LW-1:0] ln;
        logic [W-1:0] es;
        int s, el, bad;
        for (int n = 0; n < 24; n++) begin
            s = $urandom_range(0, 1);
            ab = AW'($urandom); bb = AW'($urandom); st = AW'($urandom); ca = AW'($urandom);
            ln = LW'($urandom_range(0, 12));
            fill_mem(ab, bb, st, ln);
            model_dot(ab, bb, st, ln, es);
            run_dot(s, ab, bb, st, ln, ca);
            el = 2 + 2 * int'(ln) * (1 + ((s == 0) ? 1 : 3));
            bad = (got_q.size() != exp_q.size()) ? 1 : 0;
            foreach (exp_q[k]) if (k < got_q.size() && got_q[k] !== exp_q[k]) bad = 1;
            tests++;
            if (r_wd !== es || r_wa !== ca) begin
                fails++;
                $display("FAIL random_%0d_result got %h@%h expected %h@%h", n, r_wd, r_wa, es, ca);
            end
            tests++;
            if (r_lat != el || bad != 0) begin
                fails++;
                $display("FAIL random_%0d_sequence got lat=%0d badreads=%0d expected lat=%0d 0", n, r_lat, bad, el);
            end
            tests++;
            if (r_ndone != 1 || r_nwr != 1 || r_nviol != 0) begin
                fails++;
                $display("FAIL random_%0d_strobes got done=%0d wr=%0d viol=%0d expected 1 1 0",
                         n, r_ndone, r_nwr, r_nviol);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] es;
        int dn0, wr0, n;
        sel = 0;
        #1;
        fill_mem(16'h800, 16'h900, 16'd1, 8'd3);
        model_dot(16'h800, 16'h900, 16'd1, 8'd3, es);
        dn0 = done_n_s; wr0 = wr_n_s;
        a_base = 16'h800; b_base = 16'h900; b_stride = 16'd1; len = 8'd3; c_addr = 16'h9F0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done_s && n < 60) begin
            start_v[0] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (n != 14 || busy_s !== 1'b0 || done_n_s - dn0 != 1 || wr_n_s - wr0 != 1) begin
            fails++;
            $display("FAIL start_ignored got lat=%0d busy=%b done=%0d wr=%0d expected 14 0 1 1",
                     n, busy_s, done_n_s - dn0, wr_n_s - wr0);
        end
        tests++;
        if (wr_data_s !== es) begin
            fails++;
            $display("FAIL start_ignored_result got %h expected %h", wr_data_s, es);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] es;
        int dn0, wr0, n;
        sel = 0;
        #1;
        fill_mem(16'hA00, 16'hB00, 16'd2, 8'd4);
        model_dot(16'hA00, 16'hB00, 16'd2, 8'd4, es);
        dn0 = done_n_s; wr0 = wr_n_s;
        a_base = 16'hA00; b_base = 16'hB00; b_stride = 16'd2; len = 8'd4; c_addr = 16'hBF0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done_s && n < 60) begin @(posedge clk); #1; n++; end
        tests++;
        if (n != 18 || wr_data_s !== es) begin
            fails++;
            $display("FAIL b2b_first got lat=%0d data=%h expected 18 %h", n, wr_data_s, es);
        end
        @(posedge clk); #1;
        tests++;
        if (busy_s !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap got busy=%b expected 0", busy_s);
        end
        @(posedge clk); #1;
        tests++;
        if ({busy_s, outs_s[2]} !== 2'b11) begin
            fails++;
            $display("FAIL b2b_restart got busy,ac_clear=%b expected 11", {busy_s, outs_s[2]});
        end
        start_v[0] = 1'b0;
        n = 0;
        while (!done_s && n < 60) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        tests++;
        if (n != 18 || wr_data_s !== es || done_n_s - dn0 != 2 || wr_n_s - wr0 != 2) begin
            fails++;
            $display("FAIL b2b_second got lat=%0d data=%h done=%0d wr=%0d expected 18 %h 2 2",
                     n, wr_data_s, done_n_s - dn0, wr_n_s - wr0, es);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] es;
        int dn0, wr0;
        sel = 0;
        #1;
        fill_mem(16'hC00, 16'hD00, 16'd1, 8'd3);
        dn0 = done_n_s; wr0 = wr_n_s;
        a_base = 16'hC00; b_base = 16'hD00; b_stride = 16'd1; len = 8'd3; c_addr = 16'hDF0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (outs_s[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_in_wait_b got alu_mac=%b expected 1", outs_s[0]);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({outs_s, addr_s} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs got %h expected 0", {outs_s, addr_s});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done_n_s - dn0 != 0 || wr_n_s - wr0 != 0 || busy_s !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_no_complete got done=%0d wr=%0d busy=%b expected 0 0 0",
                     done_n_s - dn0, wr_n_s - wr0, busy_s);
        end
        model_dot(16'hC00, 16'hD00, 16'd1, 8'd3, es);
        run_dot(0, 16'hC00, 16'hD00, 16'd1, 8'd3, 16'hDF0);
        tests++;
        if (r_wd !== es || r_lat != 14 || r_ndone != 1) begin
            fails++;
            $display("FAIL mid_reset_recovery got %h lat=%0d done=%0d expected %h 14 1", r_wd, r_lat, r_ndone, es);
        end
    endtask

    initial begin
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        a_base = '0; b_base = '0; b_stride = '0; len = '0; c_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_spec_vector();
        test_len_zero();
        test_wrap();
        test_mem_lat3();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
